// File: rtl/sopk_multiwave_decoder_pkg.sv
// Shared SOPK/SALU decode types and the SOPK opcode lookup table.
package sopk_multiwave_decoder_pkg;

  localparam logic [3:0] SALU_SOPK        = 4'b1011;
  localparam int         SALU_SGPR_BASE_W = 9;

  // Raw SOPK instruction word layout.
  typedef struct packed {
    logic [3:0]  itype;
    logic [4:0]  opcode;
    logic [6:0]  sdst;
    logic [15:0] simm16;
  } sopk_instr_t;

  // Operation-level controls shared by every encoding of an opcode.
  typedef struct packed {
    logic [5:0] alu_op;
    logic       rd_sdst;
    logic       wr_scc;
  } salu_common_t;

  // SGPR access request: wave base plus up to two register offsets.
  typedef struct packed {
    logic [SALU_SGPR_BASE_W-1:0] base;
    logic [1:0][6:0]             addr;
  } salu_sgpr_req_t;

  typedef struct packed {
    salu_common_t   common_params;
    salu_sgpr_req_t rd_req;
    salu_sgpr_req_t wr_req;
  } salu_instr_params_t;

  typedef struct packed {
    logic         valid;
    salu_common_t common;
  } salu_lookup_t;

  // Opcode table; unlisted opcodes are reserved and return valid=0.
  function automatic salu_lookup_t sopk_lookup_table(input logic [4:0] opcode);
    salu_lookup_t e;
    e = '0;
    case (opcode)
      5'd0:  e = '{valid: 1'b1, common: '{alu_op: 6'h01, rd_sdst: 1'b0, wr_scc: 1'b0}};
      5'd1:  e = '{valid: 1'b1, common: '{alu_op: 6'h02, rd_sdst: 1'b0, wr_scc: 1'b0}};
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13: begin
        // Compares occupy a contiguous ALU code range starting at 6'h10.
        e.valid          = 1'b1;
        e.common.alu_op  = 6'(opcode) + 6'h0E;
        e.common.rd_sdst = 1'b1;
        e.common.wr_scc  = 1'b1;
      end
      5'd14: e = '{valid: 1'b1, common: '{alu_op: 6'h04, rd_sdst: 1'b1, wr_scc: 1'b1}};
      5'd15: e = '{valid: 1'b1, common: '{alu_op: 6'h05, rd_sdst: 1'b1, wr_scc: 1'b0}};
      5'd17: e = '{valid: 1'b1, common: '{alu_op: 6'h08, rd_sdst: 1'b0, wr_scc: 1'b0}};
      5'd18: e = '{valid: 1'b1, common: '{alu_op: 6'h09, rd_sdst: 1'b1, wr_scc: 1'b0}};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/salu_sync_fifo.sv
// Synchronous FIFO with registered head output and single-cycle flush.
module salu_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_ok, pop_ok;

  // Next pointers/count and the head entry that will be presented next cycle.
  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && valid_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    valid_d  = (count_d != '0);
    rdata_d  = '0;
    // The new head may be the word being written this very cycle.
    if (valid_d) rdata_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
  end

  // Control state and registered head; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rd_valid = valid_q;
  assign rdata    = rdata_q;
  assign count    = count_q;

endmodule

// File: rtl/sopk_multiwave_decoder.sv
// SOPK decode stage: per-wave SGPR base lookup, simm16 sign extension and an
// in-order decoded-op FIFO. Optional performance counters are built when
// SOPK_DECODER_PERF_EN is defined.
module sopk_multiwave_decoder
  import sopk_multiwave_decoder_pkg::*;
#(
  parameter  int NUM_WAVES   = 8,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int SGPR_BASE_W = 9,
  parameter  int DATA_W      = 32,
  localparam int WAVE_W      = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic [WAVE_W-1:0]      in_wave,
  input  logic                   cfg_we,
  input  logic [WAVE_W-1:0]      cfg_wave,
  input  logic [SGPR_BASE_W-1:0] cfg_base,
  input  logic                   flush,
  output logic                   op_valid,
  input  logic                   op_ready,
  output salu_instr_params_t     op_params,
  output logic [DATA_W-1:0]      op_imm,
  output logic [WAVE_W-1:0]      op_wave,
  output logic                   op_illegal
`ifdef SOPK_DECODER_PERF_EN
  ,
  output logic [31:0]            perf_decoded,
  output logic [31:0]            perf_dropped,
  output logic [31:0]            perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    salu_instr_params_t  params;
    logic [DATA_W-1:0]   imm;
    logic [WAVE_W-1:0]   wave;
    logic                illegal;
  } op_bundle_t;

  logic [SGPR_BASE_W-1:0] base_q [NUM_WAVES];
  sopk_instr_t            instr;
  salu_lookup_t           lookup;
  op_bundle_t             dec, head;
  logic                   is_sopk, accept, push;
  logic [CNT_W-1:0]       fifo_count;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] imm);
    return {{(DATA_W-16){imm[15]}}, imm};
  endfunction

  assign instr    = in_data;
  assign lookup   = sopk_lookup_table(instr.opcode);
  assign is_sopk  = (instr.itype == SALU_SOPK);
  // in_ready depends only on registered count and flush, never on op_ready.
  assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH)) && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_sopk;

  // Per-wave SGPR base register file; a same-cycle decode sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n)      base_q <= '{default: '0};
    else if (cfg_we) base_q[cfg_wave] <= cfg_base;
  end

  // Combinational decode of the incoming word into the FIFO bundle.
  always_comb begin
    dec                              = '0;
    dec.params.common_params         = lookup.common;
    dec.params.rd_req.base           = SALU_SGPR_BASE_W'(base_q[in_wave]);
    dec.params.rd_req.addr[0]        = instr.sdst;
    dec.params.wr_req.base           = SALU_SGPR_BASE_W'(base_q[in_wave]);
    dec.params.wr_req.addr[0]        = instr.sdst;
    dec.imm                          = sext_imm(instr.simm16);
    dec.wave                         = in_wave;
    dec.illegal                      = ~lookup.valid;
  end

  salu_sync_fifo #(
    .WIDTH ($bits(op_bundle_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .wdata    (dec),
    .pop      (op_ready),
    .rd_valid (op_valid),
    .rdata    (head),
    .count    (fifo_count)
  );

  assign op_params  = head.params;
  assign op_imm     = head.imm;
  assign op_wave    = head.wave;
  assign op_illegal = head.illegal;

`ifdef SOPK_DECODER_PERF_EN
  logic [31:0] perf_decoded_q, perf_dropped_q, perf_stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_decoded_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push)                 perf_decoded_q <= sat_inc(perf_decoded_q);
      if (accept && !is_sopk)   perf_dropped_q <= sat_inc(perf_dropped_q);
      if (in_valid && !in_ready) perf_stall_q  <= sat_inc(perf_stall_q);
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_sopk_multiwave_decoder.sv
// Scoreboard bench for sopk_multiwave_decoder: stimulus queues expected ops,
// a negedge monitor pops and compares every handshaked output op.
module tb_sopk_multiwave_decoder;
  import sopk_multiwave_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  in_wave = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_wave = '0;
  logic [8:0]  cfg_base = '0;
  logic        flush = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  salu_instr_params_t op_params;
  logic [31:0] op_imm;
  logic [2:0]  op_wave;
  logic        op_illegal;
`ifdef SOPK_DECODER_PERF_EN
  logic [31:0] perf_decoded, perf_dropped, perf_stall;
`endif

  typedef struct packed {
    salu_instr_params_t p;
    logic [31:0]        imm;
    logic [2:0]         wave;
    logic               ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  sopk_multiwave_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wave(in_wave), .cfg_we(cfg_we), .cfg_wave(cfg_wave),
    .cfg_base(cfg_base), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
    .op_params(op_params), .op_imm(op_imm), .op_wave(op_wave), .op_illegal(op_illegal)
`ifdef SOPK_DECODER_PERF_EN
    , .perf_decoded(perf_decoded), .perf_dropped(perf_dropped), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [4:0] op, input logic [6:0] sdst, input logic [15:0] imm);
    return {4'b1011, op, sdst, imm};
  endfunction

  function automatic exp_t mke(input logic [5:0] alu, input logic rds, input logic wsc,
                               input logic [8:0] base, input logic [6:0] sdst,
                               input logic [31:0] imm, input logic [2:0] wave, input logic ill);
    exp_t e;
    e = '0;
    e.p.common_params.alu_op  = alu;
    e.p.common_params.rd_sdst = rds;
    e.p.common_params.wr_scc  = wsc;
    e.p.rd_req.base           = base;
    e.p.rd_req.addr[0]        = sdst;
    e.p.wr_req.base           = base;
    e.p.wr_req.addr[0]        = sdst;
    e.imm  = imm;
    e.wave = wave;
    e.ill  = ill;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [2:0] w, input logic [8:0] b);
    cfg_we = 1'b1; cfg_wave = w; cfg_base = b;
    tick();
    cfg_we = 1'b0;
  endtask

  // Present a word until accepted; queue its expectation at the accepting cycle.
  task automatic send(input logic [31:0] w, input logic [2:0] wv, input bit enq,
                      input exp_t e, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    in_valid = 1'b1; in_data = w; in_wave = wv;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (enq) sb.push_back(e);
      end else begin
        waited++;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance within 50 cycles", w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every completed output handshake must match the queue head.
  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_op: got op wave %0d imm %h, required no op", op_wave, op_imm);
      end else begin
        mon_e = sb.pop_front();
        chk("op_params", 64'(op_params), 64'(mon_e.p));
        chk("op_imm", 64'(op_imm), 64'(mon_e.imm));
        chk("op_wave", 64'(op_wave), 64'(mon_e.wave));
        chk("op_illegal", 64'(op_illegal), 64'(mon_e.ill));
      end
    end
  end

  initial begin
    int   wt;
    exp_t ex;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_params", 64'(op_params), 64'd0);
    chk("rst_op_imm", 64'(op_imm), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Test 1: base[3]=0x040, s_movk sdst=5 simm16=0x8001
    cfg(3'd7, 9'h1FF);
    cfg(3'd3, 9'h040);
    send(mkw(5'd0, 7'd5, 16'h8001), 3'd3, 1'b1,
         mke(6'h01, 1'b0, 1'b0, 9'h040, 7'd5, 32'hFFFF_8001, 3'd3, 1'b0), wt);
    @(negedge clk);
    chk("t1_op_valid_next_cycle", 64'(op_valid), 64'd1);
    tick();
    tick();

    // Test 2: backpressure, fill to 4, then drain with simultaneous push/pop
    op_ready = 1'b0;
    send(mkw(5'd14, 7'd10, 16'h0005), 3'd0, 1'b1, mke(6'h04, 1'b1, 1'b1, 9'h000, 7'd10, 32'h0000_0005, 3'd0, 1'b0), wt);
    send(mkw(5'd3,  7'd11, 16'hFFFF), 3'd3, 1'b1, mke(6'h11, 1'b1, 1'b1, 9'h040, 7'd11, 32'hFFFF_FFFF, 3'd3, 1'b0), wt);
    send(mkw(5'd15, 7'd12, 16'h7FFF), 3'd1, 1'b1, mke(6'h05, 1'b1, 1'b0, 9'h000, 7'd12, 32'h0000_7FFF, 3'd1, 1'b0), wt);
    send(mkw(5'd0, 7'd127, 16'h8000), 3'd7, 1'b1, mke(6'h01, 1'b0, 1'b0, 9'h1FF, 7'd127, 32'hFFFF_8000, 3'd7, 1'b0), wt);
    @(negedge clk);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_count_full", 64'(dut.fifo_count), 64'd4);
    tick();
    op_ready = 1'b1;
    send(mkw(5'd14, 7'd1, 16'h1234), 3'd3, 1'b1, mke(6'h04, 1'b1, 1'b1, 9'h040, 7'd1, 32'h0000_1234, 3'd3, 1'b0), wt);
    chk("t2_fifth_waits_one", 64'(wt), 64'd1);
    send(mkw(5'd0, 7'd2, 16'hABCD), 3'd5, 1'b1, mke(6'h01, 1'b0, 1'b0, 9'h000, 7'd2, 32'hFFFF_ABCD, 3'd5, 1'b0), wt);
    chk("t2_push_pop_no_wait", 64'(wt), 64'd0);
    send(mkw(5'd3, 7'd3, 16'h0001), 3'd6, 1'b1, mke(6'h11, 1'b1, 1'b1, 9'h000, 7'd3, 32'h0000_0001, 3'd6, 1'b0), wt);
    @(negedge clk);
    chk("t2_count_steady", 64'(dut.fifo_count), 64'd3);
    repeat (5) tick();
    @(negedge clk);
    chk("t2_drained", 64'(op_valid), 64'd0);
    tick();

    // Test 3: non-SOPK word accepted and dropped
    send(32'h8000_0000, 3'd0, 1'b0, '0, wt);
    chk("t3_nonsopk_accepted", 64'(wt), 64'd0);
    @(negedge clk);
    chk("t3_no_op", 64'(op_valid), 64'd0);
`ifdef SOPK_DECODER_PERF_EN
    chk("t3_perf_dropped", 64'(perf_dropped), 64'd1);
    chk("t3_perf_decoded", 64'(perf_decoded), 64'd8);
    chk("t3_perf_stall", 64'(perf_stall), 64'd1);
`endif
    tick();

    // Test 4: cfg write to wave 2 in the same cycle as a wave-2 decode
    cfg(3'd2, 9'h020);
    cfg_we = 1'b1; cfg_wave = 3'd2; cfg_base = 9'h010;
    send(mkw(5'd0, 7'd4, 16'h0042), 3'd2, 1'b1, mke(6'h01, 1'b0, 1'b0, 9'h020, 7'd4, 32'h0000_0042, 3'd2, 1'b0), wt);
    cfg_we = 1'b0;
    send(mkw(5'd14, 7'd6, 16'hFF00), 3'd2, 1'b1, mke(6'h04, 1'b1, 1'b1, 9'h010, 7'd6, 32'hFFFF_FF00, 3'd2, 1'b0), wt);
    repeat (3) tick();

    // Test 5: three buffered ops, flush together with in_valid
    op_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mkw(5'd0, 7'(i), 16'h0100), 3'd0, 1'b0, '0, wt);
    in_valid = 1'b1; in_data = mkw(5'd14, 7'd20, 16'h0009); in_wave = 3'd1;
    flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_flush_op_valid", 64'(op_valid), 64'd0);
    chk("t5_flush_count", 64'(dut.fifo_count), 64'd0);
    tick();
    op_ready = 1'b1;
    repeat (3) tick();

    // Test 6: illegal opcode, then reset mid-stream
    op_ready = 1'b0;
    send(mkw(5'd25, 7'd9, 16'h0010), 3'd4, 1'b0, '0, wt);
    @(negedge clk);
    chk("t6_illegal_valid", 64'(op_valid), 64'd1);
    chk("t6_illegal_flag", 64'(op_illegal), 64'd1);
    ex = mke(6'h00, 1'b0, 1'b0, 9'h000, 7'd9, 32'h0000_0010, 3'd4, 1'b1);
    chk("t6_illegal_params", 64'(op_params), 64'(ex.p));
    tick();
    send(mkw(5'd0, 7'd8, 16'h0002), 3'd3, 1'b0, '0, wt);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_op_valid", 64'(op_valid), 64'd0);
    chk("t6_rst_op_params", 64'(op_params), 64'd0);
    chk("t6_rst_op_imm", 64'(op_imm), 64'd0);
    chk("t6_rst_op_wave_illegal", 64'({op_wave, op_illegal}), 64'd0);
`ifdef SOPK_DECODER_PERF_EN
    chk("t6_rst_perf", 64'(perf_decoded | perf_dropped | perf_stall), 64'd0);
`endif
    tick();
    op_ready = 1'b1;
    for (int w = 0; w < 8; w++)
      send(mkw(5'd0, 7'(w), 16'(w)), 3'(w), 1'b1,
           mke(6'h01, 1'b0, 1'b0, 9'h000, 7'(w), 32'(w), 3'(w), 1'b0), wt);
    repeat (4) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
